// File: rtl/core_pkg.sv
// Purpose : shared types, opcode/funct encodings and decode helpers for the
//           9-bit-instruction sequencer.
// Contents: state_t, opcode/funct constants, HALT match, is_load/is_store/is_halt.
package core_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Instruction layout: [8:6] opcode, [5:4] funct (R-type), [3:0] operands.
  localparam logic [2:0] OP_R0   = 3'b000;
  localparam logic [2:0] OP_LB   = 3'b001;
  localparam logic [2:0] OP_SB   = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_BR   = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_R1   = 3'b110;
  localparam logic [2:0] OP_R2   = 3'b111;

  localparam logic [1:0] FN_LDR = 2'b10;
  localparam logic [1:0] FN_STR = 2'b11;

  // HALT is 9'b111_11_xxxx: only opcode and funct take part in the match.
  localparam logic [4:0] HALT_HI = {OP_R2, FN_STR};

  // The helpers take only the opcode+funct field (instr[8:4]).
  function automatic logic is_load(input logic [4:0] op_fn);
    return (op_fn[4:2] == OP_LB) ||
           ((op_fn[4:2] == OP_R0) && (op_fn[1:0] == FN_LDR));
  endfunction

  function automatic logic is_store(input logic [4:0] op_fn);
    return (op_fn[4:2] == OP_SB) ||
           ((op_fn[4:2] == OP_R0) && (op_fn[1:0] == FN_STR));
  endfunction

  function automatic logic is_halt(input logic [4:0] op_fn);
    return op_fn == HALT_HI;
  endfunction

endpackage

// File: rtl/core_sequencer_sat_counter.sv
// Purpose : saturating up-counter with synchronous clear.
// Latency : count reflects clear/inc one cycle after they are sampled.
// Ports   : clk, reset (sync, active-high), i_clear, i_inc -> o_count.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      // Stick at all-ones rather than wrapping back to zero.
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/core_sequencer.sv
// Purpose : multi-cycle fetch/execute sequencer; owns PC and IR, gates the
//           decoder write strobes, stalls on data-memory ready, detects HALT.
// Latency : 2 cycles per instruction, +1 per cycle mem_ready arrives late.
// Backpr. : holds mem_req/mem_we in MEM_WAIT until mem_ready; no retry after reset.
// Ports   : clk/reset/start from host; instr_in from ROM at pc; branch,
//           pc_target, ctl_reg_write from decoder; mem_ready from data memory.
//           Outputs pc, ir, reg_we, mem_req, mem_we, done, cycle_cnt, instr_cnt.
module core_sequencer
  import core_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int START_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       instr_in,
  input  logic             branch,
  input  logic [PC_W-1:0]  pc_target,
  input  logic             ctl_reg_write,
  input  logic             mem_ready,
  output logic [PC_W-1:0]  pc,
  output logic [8:0]       ir,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic [8:0]      r_ir;
  logic            w_ir_load;
  logic            w_retire;
  logic            w_cnt_clr;
  logic            w_active;
  logic            w_ir_ld;
  logic            w_ir_st;
  logic            w_ir_mem;

  // Decode of the latched instruction; only opcode+funct matter here.
  assign w_ir_ld  = is_load(r_ir[8:4]);
  assign w_ir_st  = is_store(r_ir[8:4]);
  assign w_ir_mem = w_ir_ld || w_ir_st;
  assign w_pc_inc = r_pc + PC_W'(1);   // wraps modulo 2**PC_W

  // ---------------------------------------------------------------------
  // State, PC and IR registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_ir_load) begin
        r_ir <= instr_in;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next state, next PC and combinational strobes
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_load   = 1'b0;
    w_retire    = 1'b0;
    w_cnt_clr   = 1'b0;
    reg_we      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    done        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = START_ADDR;
          w_cnt_clr   = 1'b1;
        end
      end

      S_FETCH: begin
        w_ir_load = 1'b1;
        // HALT is caught here so it never reaches EXEC and never retires.
        if (is_halt(instr_in[8:4])) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        if (w_ir_mem) begin
          // Memory ops ignore branch; they always fall through to pc+1.
          mem_req = 1'b1;
          mem_we  = w_ir_st;
          if (mem_ready) begin
            reg_we      = w_ir_ld;
            w_retire    = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_MEM_WAIT;
          end
        end else begin
          reg_we      = ctl_reg_write;
          w_retire    = 1'b1;
          w_pc_nxt    = branch ? pc_target : w_pc_inc;
          w_state_nxt = S_FETCH;
        end
      end

      S_MEM_WAIT: begin
        // Request stays up; the register write lands only in the ready cycle.
        mem_req = 1'b1;
        mem_we  = w_ir_st;
        if (mem_ready) begin
          reg_we      = w_ir_ld;
          w_retire    = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_FETCH;
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = START_ADDR;
          w_cnt_clr   = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Cycles count only while a program is actually running.
  assign w_active = (r_state == S_FETCH) || (r_state == S_EXEC) ||
                    (r_state == S_MEM_WAIT);

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_cnt_clr),
    .i_inc   (w_active),
    .o_count (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_cnt_clr),
    .i_inc   (w_retire),
    .o_count (instr_cnt)
  );

  assign pc = r_pc;
  assign ir = r_ir;

endmodule
